// File: rtl/countdown_sequencer_pkg.sv
// Shared definitions for the mm:ss countdown sequencer and its BCD counter chain.
package countdown_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned BCD_WIDTH = 4;
  localparam int unsigned DIGITS_W  = 4 * BCD_WIDTH;

  localparam logic [BCD_WIDTH-1:0] BCD_ZERO = '0;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

endpackage

// File: rtl/countdown_sequencer_if.sv
// User pulses, chain value and chain control between the sequencer and the counters.
interface countdown_sequencer_if;
  import countdown_sequencer_pkg::*;

  logic                start_stop;
  logic                clear;
  logic [DIGITS_W-1:0] digits;
  logic                cnt_rst_n;
  logic                cnt_en;
  logic                cnt_decrease;
  logic [1:0]          state;
  logic                alarm;
  logic                blink;

  modport master (
    output start_stop, clear, digits,
    input  cnt_rst_n, cnt_en, cnt_decrease, state, alarm, blink
  );

  modport slave (
    input  start_stop, clear, digits,
    output cnt_rst_n, cnt_en, cnt_decrease, state, alarm, blink
  );

endinterface

// File: rtl/countdown_sequencer_tick_prescaler.sv
// Cycle prescaler: counts 0..TICK_DIV-1 while run is high, flags the last count as tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        clr,
  output logic                        tick,
  output logic [$clog2(TICK_DIV)-1:0] phase
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick  = run && (count == LAST);
  assign phase = count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Start/pause/resume/reload controller pacing a cascaded BCD mm:ss downcounter chain.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input logic                  clk,
  input logic                  rst,
  countdown_sequencer_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  seq_state_t    state_q;
  logic          cnt_rst_n_q;
  logic          cnt_en_q;
  logic          cnt_decrease_q;
  logic          alarm_q;
  logic          blink_q;

  logic          zero;
  logic          reload;
  logic          run;
  logic          clr;
  logic          tick;
  logic [PW-1:0] phase;

  assign zero   = (bus.digits == {4{BCD_ZERO}});
  assign reload = bus.clear || ((state_q == DONE) && bus.start_stop);
  // Prescaler free-runs in DONE so the same counter paces the blink.
  assign run    = (state_q == RUN) || (state_q == DONE);
  assign clr    = reload || (state_q == IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clr   (clr),
    .tick  (tick),
    .phase (phase)
  );

  // cnt_en never drops after reset: en=0 zeroes the counters, so holding is done
  // purely by withholding cnt_decrease.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_rst_n_q    <= 1'b0;
      cnt_en_q       <= DISABLED;
      cnt_decrease_q <= 1'b0;
      alarm_q        <= 1'b0;
      blink_q        <= 1'b0;
    end else begin
      cnt_en_q       <= ENABLED;
      cnt_rst_n_q    <= ~reload;
      cnt_decrease_q <= 1'b0;
      if (reload) begin
        state_q <= IDLE;
        alarm_q <= 1'b0;
        blink_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE:  if (bus.start_stop && !zero) state_q <= RUN;
          RUN: begin
            if (zero) begin
              state_q <= DONE;
              alarm_q <= 1'b1;
            end else begin
              cnt_decrease_q <= (phase == LAST);
              if (bus.start_stop) state_q <= PAUSE;
            end
          end
          PAUSE: if (bus.start_stop) state_q <= RUN;
          DONE:  if (tick) blink_q <= ~blink_q;
        endcase
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.cnt_rst_n    = cnt_rst_n_q;
  assign bus.cnt_en       = cnt_en_q;
  assign bus.cnt_decrease = cnt_decrease_q;
  assign bus.alarm        = alarm_q;
  assign bus.blink        = blink_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench: behavioural BCD chain around the sequencer, seconds-level reference model.
module tb_countdown_sequencer;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] preset;

  countdown_sequencer_if bus ();

  countdown_sequencer #(
    .TICK_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [15:0] r;
    logic        b;
    r = d;
    b = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Four cascaded downcounters: reload beats enable beats decrease.
  always @(posedge clk) begin
    if (bus.cnt_rst_n === 1'b0)       bus.digits <= preset;
    else if (bus.cnt_en === 1'b0)     bus.digits <= '0;
    else if (bus.cnt_decrease === 1'b1) bus.digits <= bcd_dec(bus.digits);
  end

  function automatic int from_bcd(input logic [15:0] d);
    return 600 * int'(d[15:12]) + 60 * int'(d[11:8]) + 10 * int'(d[7:4]) + int'(d[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, sec;
    if (s < 0) return 16'hFFFF;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  // Reference model: remaining seconds, run-phase count and DONE wrap count.
  int m_secs, e_state, ph, wraps;
  bit e_rst_n, e_en, e_dec;
  int n_vec, n_err, dec_seen;

  task automatic model_edge(input bit ss, input bit cl, input bit r);
    bit zero, reload, wrap;
    zero = (m_secs == 0);
    if (!e_rst_n)    m_secs = from_bcd(preset);
    else if (!e_en)  m_secs = 0;
    else if (e_dec)  m_secs = m_secs - 1;
    if (r) begin
      e_state = 0; e_rst_n = 0; e_en = 0; e_dec = 0; ph = 0; wraps = 0;
    end else begin
      reload  = cl || (e_state == 3 && ss);
      wrap    = (e_state == 1 || e_state == 3) && (ph == DIV - 1);
      e_en    = 1;
      e_rst_n = !reload;
      e_dec   = 0;
      if (reload) begin
        e_state = 0; ph = 0;
      end else begin
        if (e_state == 1 || e_state == 3) ph = (ph + 1) % DIV;
        case (e_state)
          0: if (ss && !zero) e_state = 1;
          1: if (zero) e_state = 3; else begin e_dec = wrap; if (ss) e_state = 2; end
          2: if (ss) e_state = 1;
          3: if (wrap) wraps++;
          default: e_state = 0;
        endcase
      end
      if (e_state != 3) wraps = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit ss, input bit cl, input bit r);
    bus.start_stop = ss;
    bus.clear      = cl;
    rst            = r;
    @(posedge clk);
    #1;
    model_edge(ss, cl, r);
    if (bus.cnt_decrease === 1'b1) dec_seen++;
    chk("state",        32'(bus.state),        32'(e_state));
    chk("cnt_rst_n",    32'(bus.cnt_rst_n),    32'(e_rst_n));
    chk("cnt_en",       32'(bus.cnt_en),       32'(e_en));
    chk("cnt_decrease", 32'(bus.cnt_decrease), 32'(e_dec));
    chk("alarm",        32'(bus.alarm),        32'(e_state == 3));
    chk("blink",        32'(bus.blink),        32'(e_state == 3 && wraps[0]));
    chk("digits",       32'(bus.digits),       32'(to_bcd(m_secs)));
  endtask

  initial begin
    n_vec = 0; n_err = 0; dec_seen = 0;
    preset = 16'h0003;
    bus.digits = 16'h0003;
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    rst = 1'b1;
    m_secs = 3; e_state = 0; ph = 0; wraps = 0;
    e_rst_n = 1; e_en = 1; e_dec = 0;

    // 1: reset and the one-cycle reload after it
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_reload", 32'(bus.cnt_rst_n), 32'd0);
    step(0, 0, 0);
    chk("post_rst_reload", 32'(bus.cnt_rst_n), 32'd1);
    chk("post_rst_en", 32'(bus.cnt_en), 32'd1);
    step(0, 0, 0);

    // 2: full 00:03 run into DONE, blink, then start_stop reloads
    dec_seen = 0;
    step(1, 0, 0);
    for (int k = 0; k < 24; k++) step(0, 0, 0);
    chk("run_dec_count", 32'(dec_seen), 32'd3);
    chk("done_state", 32'(bus.state), 32'd3);
    chk("done_alarm", 32'(bus.alarm), 32'd1);
    step(1, 0, 0);
    chk("done_exit_state", 32'(bus.state), 32'd0);
    chk("done_exit_reload", 32'(bus.cnt_rst_n), 32'd0);
    step(0, 0, 0);
    chk("done_exit_digits", 32'(bus.digits), 32'h0003);

    // 3: pause two cycles after a tick, hold, resume keeps phase, borrow 10->09
    preset = 16'h0012;
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 12 && !e_dec; k++) step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0);
    chk("pause_state", 32'(bus.state), 32'd2);
    chk("pause_hold", 32'(bus.digits), 32'h0011);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("resume_no_tick", 32'(bus.cnt_decrease), 32'd0);
    step(0, 0, 0);
    chk("resume_tick", 32'(bus.cnt_decrease), 32'd1);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    chk("borrow_09", 32'(bus.digits), 32'h0009);

    // 4: start at 00:00 is ignored
    preset = 16'h0000;
    step(0, 1, 0);
    step(0, 0, 0);
    dec_seen = 0;
    step(1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0);
    chk("zero_start_state", 32'(bus.state), 32'd0);
    chk("zero_start_dec", 32'(dec_seen), 32'd0);

    // 5: clear beats start_stop in RUN
    preset = 16'h0005;
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0);
    step(1, 1, 0);
    chk("clr_prio_state", 32'(bus.state), 32'd0);
    chk("clr_prio_reload", 32'(bus.cnt_rst_n), 32'd0);
    step(0, 0, 0);
    chk("clr_reload_once", 32'(bus.cnt_rst_n), 32'd1);
    chk("clr_digits", 32'(bus.digits), 32'h0005);

    // 6: rst while running at 00:01
    preset = 16'h0003;
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 30 && m_secs != 1; k++) step(0, 0, 0);
    step(0, 0, 1);
    chk("rst_run_state", 32'(bus.state), 32'd0);
    chk("rst_run_alarm", 32'(bus.alarm), 32'd0);
    step(0, 0, 0);
    chk("rst_run_digits", 32'(bus.digits), 32'h0003);

    // Random pulses against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(30) == 0) preset = to_bcd(int'($urandom_range(14)));
      step($urandom_range(7) == 0, $urandom_range(40) == 0, $urandom_range(150) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
